// File: rtl/serial_nibble_add_ctrl_if.sv
// rtl/serial_nibble_add_ctrl_if.sv - operand/result handshakes and external 4-bit adder bus
// Bundles the operand/result handshakes and the external ripple-carry adder connection.
interface serial_nibble_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [3:0]   rca_a;
  logic [3:0]   rca_b;
  logic [3:0]   rca_s;
  logic         rca_c3;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, rca_s, rca_c3,
    input  in_ready, out_valid, out_sum, out_cout, rca_a, rca_b
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, rca_s, rca_c3,
    output in_ready, out_valid, out_sum, out_cout, rca_a, rca_b
  );
endinterface

// File: rtl/serial_nibble_add_ctrl.sv
// rtl/serial_nibble_add_ctrl.sv - nibble-serial adder controller around an external 4-bit RCA
// Optional ADD_SELFCHECK_EN adds sticky chk_err comparing each result with a reference sum.
module serial_nibble_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_nibble_add_ctrl_if.slave bus,
  output logic                   busy
`ifdef ADD_SELFCHECK_EN
  ,
  output logic                   chk_err
`endif
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, INC, DONE} state_t;

  state_t          state, next_state;
  logic [W-1:0]    a_q, b_q, work_q, work_nx, sum_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW+1:0] base;
  logic            carry_q, carry_nx, c1_q, cout_q;
  logic            advance, last;

  assign base = {idx_q, 2'b00};
  assign last = (idx_q == IDXW'(NIBBLES - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign busy          = (state != IDLE);

  // Adder operands kept apart from the rca_s consumer so there is no block-level loop.
  always_comb begin
    bus.rca_a = 4'd0;
    bus.rca_b = 4'd0;
    case (state)
      ADD: begin
        bus.rca_a = a_q[base +: 4];
        bus.rca_b = b_q[base +: 4];
      end
      INC: begin
        bus.rca_a = work_q[base +: 4];
        bus.rca_b = 4'b0001;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    work_nx    = work_q;
    carry_nx   = carry_q;
    advance    = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) next_state = ADD;
      ADD: begin
        work_nx[base +: 4] = bus.rca_s;
        if (carry_q) begin
          next_state = INC;
        end else begin
          carry_nx = bus.rca_c3;
          advance  = 1'b1;
        end
      end
      INC: begin
        work_nx[base +: 4] = bus.rca_s;
        carry_nx           = c1_q | bus.rca_c3;
        advance            = 1'b1;
      end
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (advance) next_state = last ? DONE : ADD;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.in_a;
          b_q     <= bus.in_b;
          carry_q <= bus.in_cin;
          work_q  <= '0;
          idx_q   <= '0;
          c1_q    <= 1'b0;
        end
        ADD, INC: begin
          work_q  <= work_nx;
          carry_q <= carry_nx;
          if (state == ADD) c1_q <= bus.rca_c3;
          if (advance && !last) idx_q <= idx_q + IDXW'(1);
          // Result registers only change when a new result completes.
          if (advance && last) begin
            sum_q  <= work_nx;
            cout_q <= carry_nx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ADD_SELFCHECK_EN
  logic cin_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cin_q   <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) cin_q <= bus.in_cin;
      if ((state == ADD || state == INC) && advance && last &&
          ({carry_nx, work_nx} != ({1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q})))
        chk_err <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// tb/tb_serial_nibble_add_ctrl.sv - randomized and directed bench for serial_nibble_add_ctrl
module tb_serial_nibble_add_ctrl;
  logic clk;
  logic reset;
  logic busy4, busy1;
`ifdef ADD_SELFCHECK_EN
  logic chk4, chk1;
`endif
  int n_tests = 0;
  int n_fail  = 0;

  serial_nibble_add_ctrl_if #(.NIBBLES(4)) b4 ();
  serial_nibble_add_ctrl_if #(.NIBBLES(1)) b1 ();

  // External combinational ripple-carry adders
  assign {b4.rca_c3, b4.rca_s} = {1'b0, b4.rca_a} + {1'b0, b4.rca_b};
  assign {b1.rca_c3, b1.rca_s} = {1'b0, b1.rca_a} + {1'b0, b1.rca_b};

  serial_nibble_add_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4), .busy(busy4)
`ifdef ADD_SELFCHECK_EN
    , .chk_err(chk4)
`endif
  );

  serial_nibble_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .busy(busy1)
`ifdef ADD_SELFCHECK_EN
    , .chk_err(chk1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
  endfunction

  // One INC pass per nibble whose incoming carry is 1.
  function automatic int ref_lat(input int nib, input logic [15:0] a, input logic [15:0] b, input logic cin);
    longint mask, part;
    int lat = nib;
    for (int i = 0; i < nib; i++) begin
      mask = (longint'(1) << (4 * i)) - 1;
      part = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
      lat += int'((part >> (4 * i)) & 1);
    end
    return lat;
  endfunction

  task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output int lat, output logic [15:0] s, output logic co);
    @(negedge clk);
    b4.in_a = a; b4.in_b = b; b4.in_cin = cin; b4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!b4.out_valid && lat < 40);
    if (!b4.out_valid) lat = -1;
    s  = b4.out_sum;
    co = b4.out_cout;
    b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output int lat, output logic [3:0] s, output logic co);
    @(negedge clk);
    b1.in_a = a; b1.in_b = b; b1.in_cin = cin; b1.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!b1.out_valid && lat < 10);
    if (!b1.out_valid) lat = -1;
    s  = b1.out_sum;
    co = b1.out_cout;
    b1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({b4.in_ready, b4.out_valid, busy4, b4.out_cout} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags got %b want 1000", {b4.in_ready, b4.out_valid, busy4, b4.out_cout});
    end
    n_tests++;
    if ({b4.out_sum, b4.rca_a, b4.rca_b} !== 24'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {b4.out_sum, b4.rca_a, b4.rca_b});
    end
    n_tests++;
    if ({b1.in_ready, b1.out_valid, busy1} !== 3'b100) begin
      n_fail++; $display("FAIL reset_n1 got %b want 100", {b1.in_ready, b1.out_valid, busy1});
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [3] = '{16'h0001, 16'hFFFF, 16'h000F};
    logic [15:0] tb_ [3] = '{16'h0002, 16'h0000, 16'h0001};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] ws [3] = '{16'h0003, 16'h0000, 16'h0010};
    logic        wc [3] = '{1'b0, 1'b1, 1'b0};
    int          wl [3] = '{4, 8, 5};
    int lat; logic [15:0] s; logic co;
    for (int i = 0; i < 3; i++) begin
      do_op4(ta[i], tb_[i], tc[i], lat, s, co);
      n_tests++;
      if (s !== ws[i] || co !== wc[i] || lat != wl[i]) begin
        n_fail++;
        $display("FAIL directed_%0d got sum=%h cout=%b lat=%0d want sum=%h cout=%b lat=%0d",
                 i, s, co, lat, ws[i], wc[i], wl[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [16:0] exp = ref_sum(16'h1234, 16'h0FFF, 1'b1);
    int lat = 0;
    @(negedge clk);
    b4.in_a = 16'h1234; b4.in_b = 16'h0FFF; b4.in_cin = 1'b1; b4.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b4.in_valid = 1'b0;
    while (!b4.out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    n_tests++;
    if (b4.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_timeout got out_valid=%b want 1", b4.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      b4.in_valid = ~b4.in_valid;
      b4.in_a = 16'($urandom);
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (b4.out_valid !== 1'b1 || {b4.out_cout, b4.out_sum} !== exp || b4.in_ready !== 1'b0 ||
          {b4.rca_a, b4.rca_b} !== 8'h0) begin
        n_fail++;
        $display("FAIL hold_%0d got valid=%b res=%h ready=%b rca=%h want valid=1 res=%h ready=0 rca=0",
                 i, b4.out_valid, {b4.out_cout, b4.out_sum}, b4.in_ready, {b4.rca_a, b4.rca_b}, exp);
      end
    end
    // Handshake edge with in_valid high: must not accept in that same cycle.
    b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    n_tests++;
    if (b4.out_valid !== 1'b0 || busy4 !== 1'b0 || b4.in_ready !== 1'b1 ||
        {b4.out_cout, b4.out_sum} !== exp) begin
      n_fail++;
      $display("FAIL hold_release got valid=%b busy=%b ready=%b res=%h want 0 0 1 %h",
               b4.out_valid, busy4, b4.in_ready, {b4.out_cout, b4.out_sum}, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat = 0; logic [15:0] s; logic co;
    logic [16:0] exp = ref_sum(16'hABCD, 16'h1234, 1'b1);
    @(negedge clk);
    b4.in_a = 16'h1234; b4.in_b = 16'h1111; b4.in_cin = 1'b0; b4.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b4.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || busy4 !== 1'b0 || b4.out_sum !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid got ready=%b valid=%b busy=%b sum=%h want 1 0 0 0000",
               b4.in_ready, b4.out_valid, busy4, b4.out_sum);
    end
    do_op4(16'hABCD, 16'h1234, 1'b1, lat, s, co);
    n_tests++;
    if ({co, s} !== exp || lat != ref_lat(4, 16'hABCD, 16'h1234, 1'b1)) begin
      n_fail++; $display("FAIL after_reset got res=%h lat=%0d want %h", {co, s}, lat, exp);
    end
    // Reset in DONE wins over a simultaneous result handshake.
    @(negedge clk);
    b4.in_a = 16'hFFFF; b4.in_b = 16'h0001; b4.in_cin = 1'b0; b4.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    b4.in_valid = 1'b0;
    lat = 0;
    while (!b4.out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    reset = 1'b1; b4.out_ready = 1'b1; b4.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0; b4.out_ready = 1'b0; b4.in_valid = 1'b0;
    n_tests++;
    if (b4.out_valid !== 1'b0 || busy4 !== 1'b0 || {b4.out_cout, b4.out_sum} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_done got valid=%b busy=%b res=%h want 0 0 0",
               b4.out_valid, busy4, {b4.out_cout, b4.out_sum});
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] s, a, b; logic co, c;
    for (int i = 0; i < 50; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (i % 5 == 0) b = ~a;
      do_op4(a, b, c, lat, s, co);
      n_tests++;
      if ({co, s} !== ref_sum(a, b, c) || lat != ref_lat(4, a, b, c)) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h cin=%b got res=%h lat=%0d want res=%h lat=%0d",
                 i, a, b, c, {co, s}, lat, ref_sum(a, b, c), ref_lat(4, a, b, c));
      end
    end
  endtask

  task automatic test_exhaustive_n1();
    int lat; logic [3:0] s, a, b; logic co, c; int bad = 0;
    for (int i = 0; i < 512; i++) begin
      a = 4'(i); b = 4'(i >> 4); c = 1'(i >> 8);
      do_op1(a, b, c, lat, s, co);
      n_tests++;
      if ({co, s} !== 5'(ref_sum({12'h0, a}, {12'h0, b}, c)) || lat != ref_lat(1, {12'h0, a}, {12'h0, b}, c)) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL n1_%0d got res=%h lat=%0d want res=%h lat=%0d", i, {co, s}, lat,
                   5'(ref_sum({12'h0, a}, {12'h0, b}, c)), ref_lat(1, {12'h0, a}, {12'h0, b}, c));
        bad++;
      end
    end
`ifdef ADD_SELFCHECK_EN
    n_tests++;
    if (chk1 !== 1'b0 || chk4 !== 1'b0) begin
      n_fail++; $display("FAIL chk_err got %b%b want 00", chk1, chk4);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_cin = 1'b0; b4.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_cin = 1'b0; b1.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    test_exhaustive_n1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
